// File: rtl/imem_boot_sequencer.sv
// Boot sequencer: holds the core in reset, streams a length-prefixed byte image
// into instruction memory one 32-bit word at a time, then releases the core.
module imem_boot_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [15:0]           r_len;
  logic [15:0]           r_words;
  logic [1:0]            r_byte_idx;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [TW-1:0]         r_tmo;

  logic                  w_accept;
  logic                  w_hs;
  logic                  w_tmo_hit;
  logic [15:0]           w_len;

  // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
  // byte_ready depends only on state, never combinationally on byte_valid.
  assign w_accept   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
  assign w_hs       = byte_valid && w_accept;
  assign w_tmo_hit  = (r_tmo == TMO_LAST);
  assign w_len      = {byte_data, r_len[7:0]};
  assign byte_ready = w_accept;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_word;
  assign dbg_state  = r_state;

  always_comb begin
    w_next_state = r_state;
    imem_we      = 1'b0;
    core_rst     = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_LEN_LO;
      end
      S_LEN_LO: begin
        busy = 1'b1;
        if (w_hs)           w_next_state = S_LEN_HI;
        else if (w_tmo_hit) w_next_state = S_ERROR;
      end
      S_LEN_HI: begin
        busy = 1'b1;
        if (w_hs) begin
          if (w_len == 16'd0)                  w_next_state = S_RUN;
          else if ({1'b0, w_len} > 17'(DEPTH)) w_next_state = S_ERROR;
          else                                 w_next_state = S_DATA;
        end else if (w_tmo_hit) begin
          w_next_state = S_ERROR;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (w_hs) begin
          if (r_byte_idx == 2'd3) w_next_state = S_WRITE;
        end else if (w_tmo_hit) begin
          w_next_state = S_ERROR;
        end
      end
      S_WRITE: begin
        busy    = 1'b1;
        imem_we = 1'b1;
        if (r_words + 16'd1 == r_len) w_next_state = S_RUN;
        else                          w_next_state = S_DATA;
      end
      S_RUN: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (start) w_next_state = S_LEN_LO;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) w_next_state = S_LEN_LO;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_words    <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_addr     <= '0;
      r_tmo      <= '0;
    end else begin
      r_state <= w_next_state;

      // Idle-cycle counter restarts on every accepted byte and on any state change.
      if (!w_accept || w_hs || (w_next_state != r_state)) r_tmo <= '0;
      else                                                r_tmo <= r_tmo + TW'(1);

      case (r_state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            r_len      <= '0;
            r_words    <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_addr     <= '0;
          end
        end
        S_LEN_LO: if (w_hs) r_len[7:0]  <= byte_data;
        S_LEN_HI: if (w_hs) r_len[15:8] <= byte_data;
        S_DATA: begin
          if (w_hs) begin
            // Shift in from the top so the first byte lands in bits 7:0.
            r_word     <= {byte_data, r_word[31:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + ADDR_WIDTH'(1);
          r_words <= r_words + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Self-checking bench for imem_boot_sequencer: cycle table for the main image
// flows, hand-written sequences for timeout and asynchronous reset corners.
module tb_imem_boot_sequencer;

  localparam int AW  = 8;
  localparam int TMO = 1000;

  localparam int C_IDLE = 0;
  localparam int C_ACC  = 1;
  localparam int C_WR   = 2;
  localparam int C_RUN  = 3;
  localparam int C_ERR  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];

  imem_boot_sequencer #(
    .ADDR_WIDTH(AW), .DEPTH(256), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 1000000");
    $fatal(1, "global timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int code,
                               input logic [AW-1:0] a, input logic [31:0] w);
    check({tag, "_ready"},    40'(byte_ready), 40'(code == C_ACC));
    check({tag, "_we"},       40'(imem_we),    40'(code == C_WR));
    check({tag, "_core_rst"}, 40'(core_rst),   40'(code != C_RUN));
    check({tag, "_busy"},     40'(busy),       40'(code == C_ACC || code == C_WR));
    check({tag, "_done"},     40'(done),       40'(code == C_RUN));
    check({tag, "_error"},    40'(error),      40'(code == C_ERR));
    if (code == C_WR) begin
      check({tag, "_addr"},  40'(imem_addr),  40'(a));
      check({tag, "_wdata"}, 40'(imem_wdata), 40'(w));
    end
  endtask

  // Scoreboard: every write cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_stall: byte_ready stayed 0, required 1 within 100 cycles");
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!(done || error) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"},  40'(done),  40'd1);
    check({name, "_error"}, 40'(error), 40'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          s;
    logic          v;
    logic [7:0]    d;
    int            code;
    logic [AW-1:0] a;
    logic [31:0]   w;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input int code, input logic [AW-1:0] a, input logic [31:0] w);
    vec_t r;
    r.s = s; r.v = v; r.d = d; r.code = code; r.a = a; r.w = w;
    return r;
  endfunction

  logic [31:0] img[5];

  initial begin
    // two-word image, byte offered during WRITE must be ignored
    vecs[0]  = mk(1, 0, 8'h00, C_IDLE, 0, 0);
    vecs[1]  = mk(0, 1, 8'h02, C_ACC,  0, 0);
    vecs[2]  = mk(0, 1, 8'h00, C_ACC,  0, 0);
    vecs[3]  = mk(0, 1, 8'h13, C_ACC,  0, 0);
    vecs[4]  = mk(0, 1, 8'h05, C_ACC,  0, 0);
    vecs[5]  = mk(0, 1, 8'hA0, C_ACC,  0, 0);
    vecs[6]  = mk(0, 1, 8'h00, C_ACC,  0, 0);
    vecs[7]  = mk(0, 1, 8'hFF, C_WR,   0, 32'h00A00513);
    vecs[8]  = mk(0, 1, 8'h93, C_ACC,  0, 0);
    vecs[9]  = mk(0, 1, 8'h05, C_ACC,  0, 0);
    vecs[10] = mk(0, 1, 8'h50, C_ACC,  0, 0);
    vecs[11] = mk(0, 1, 8'h00, C_ACC,  0, 0);
    vecs[12] = mk(0, 0, 8'h00, C_WR,   1, 32'h00500593);
    vecs[13] = mk(0, 1, 8'h77, C_RUN,  0, 0);
    // zero-length image: RUN right after the LEN_HI handshake
    vecs[14] = mk(1, 0, 8'h00, C_RUN,  0, 0);
    vecs[15] = mk(0, 1, 8'h00, C_ACC,  0, 0);
    vecs[16] = mk(0, 1, 8'h00, C_ACC,  0, 0);
    vecs[17] = mk(0, 0, 8'h00, C_RUN,  0, 0);
    // oversize length 257, then recovery with a one-word image
    vecs[18] = mk(1, 0, 8'h00, C_RUN,  0, 0);
    vecs[19] = mk(0, 1, 8'h01, C_ACC,  0, 0);
    vecs[20] = mk(0, 1, 8'h01, C_ACC,  0, 0);
    vecs[21] = mk(0, 0, 8'h00, C_ERR,  0, 0);
    vecs[22] = mk(1, 0, 8'h00, C_ERR,  0, 0);
    vecs[23] = mk(1, 1, 8'h01, C_ACC,  0, 0);
    vecs[24] = mk(0, 1, 8'h00, C_ACC,  0, 0);
    vecs[25] = mk(0, 1, 8'hEF, C_ACC,  0, 0);
    vecs[26] = mk(1, 1, 8'hBE, C_ACC,  0, 0);
    vecs[27] = mk(0, 1, 8'hAD, C_ACC,  0, 0);
    vecs[28] = mk(0, 1, 8'hDE, C_ACC,  0, 0);
    vecs[29] = mk(0, 0, 8'h00, C_WR,   0, 32'hDEADBEEF);
    vecs[30] = mk(0, 0, 8'h00, C_RUN,  0, 0);
    vecs[31] = mk(0, 0, 8'h00, C_RUN,  0, 0);

    img[0] = 32'h11223344; img[1] = 32'hA5A55A5A; img[2] = 32'h00000013;
    img[3] = 32'hCAFEF00D; img[4] = 32'h80000001;

    // reset held, then released with no start: must sit in IDLE
    #12;
    check_outputs("in_reset", C_IDLE, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_outputs($sformatf("idle%0d", i), C_IDLE, 0, 0);
    end

    exp_q.push_back({8'h00, 32'h00A00513});
    exp_q.push_back({8'h01, 32'h00500593});
    exp_q.push_back({8'h00, 32'hDEADBEEF});
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].w);
      start      = vecs[i].s;
      byte_valid = vecs[i].v;
      byte_data  = vecs[i].d;
    end

    // asynchronous reset while the core runs: core_rst must rise before any edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_core_rst", 40'(core_rst), 40'd1);
    check("async_rst_done",     40'(done),     40'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // timeout: one byte into the data phase, then silence
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    for (int i = 1; i <= TMO; i++) @(negedge clk);
    check("tmo_last_cycle_error", 40'(error),      40'd0);
    check("tmo_last_cycle_ready", 40'(byte_ready), 40'd1);
    @(negedge clk);
    check("tmo_error",    40'(error),      40'd1);
    check("tmo_core_rst", 40'(core_rst),   40'd1);
    check("tmo_ready",    40'(byte_ready), 40'd0);
    check("tmo_busy",     40'(busy),       40'd0);

    // byte arriving exactly at the terminal count is accepted
    pulse_start();
    #1;
    check("restart_error_clear", 40'(error), 40'd0);
    check("restart_busy",        40'(busy),  40'd1);
    exp_q.push_back({8'h00, 32'hDDCCBBAA});
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'hBB);
    check("tmo_edge_no_error", 40'(error), 40'd0);
    send_byte(8'hCC);
    send_byte(8'hDD);
    wait_done("tmo_edge");

    // asynchronous reset after three of five words
    pulse_start();
    for (int i = 0; i < 3; i++) exp_q.push_back({AW'(i), img[i]});
    send_byte(8'h05);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_word(img[i]);
    send_byte(img[3][7:0]);
    send_byte(img[3][15:8]);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_core_rst", 40'(core_rst),   40'd1);
    check("midrst_ready",    40'(byte_ready), 40'd0);
    check("midrst_we",       40'(imem_we),    40'd0);
    check("midrst_addr",     40'(imem_addr),  40'd0);
    check("midrst_wdata",    40'(imem_wdata), 40'd0);
    check("midrst_busy",     40'(busy),       40'd0);
    check("midrst_done",     40'(done),       40'd0);
    check("midrst_error",    40'(error),      40'd0);
    check("midrst_pending",  40'(exp_q.size()), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full reload, with a start pulse mid-stream that must be ignored
    pulse_start();
    for (int i = 0; i < 5; i++) exp_q.push_back({AW'(i), img[i]});
    send_byte(8'h05);
    send_byte(8'h00);
    send_word(img[0]);
    send_word(img[1]);
    pulse_start();
    check("busy_start_ignored", 40'(busy), 40'd1);
    for (int i = 2; i < 5; i++) send_word(img[i]);
    wait_done("reload");
    check("reload_core_rst", 40'(core_rst), 40'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 40'(exp_q.size()), 40'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_sequencer.md
Name: imem_boot_sequencer

Overview:
- Boot controller sequencing the single-cycle RISC-V core at power-up or on request.
- Holds the core in reset while streaming a byte-serial program image into instruction memory through a dedicated write port, then releases the core to run.
- Sits between an external byte source (UART receiver or debug bridge) and the core's instruction-memory write port and core reset input.

Parameters:
- ADDR_WIDTH, 8, width of the instruction-memory word address.
- DEPTH, 256, number of 32-bit words in instruction memory (≤ 2**ADDR_WIDTH).
- TIMEOUT_CYCLES, 1000, maximum idle cycles between accepted bytes before an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load, honoured in IDLE, RUN and ERROR.
- byte_valid  in  1  byte source has byte_data available.
- byte_data  in  8  stream byte.
- byte_ready  out  1  sequencer can accept a byte; transfer occurs when byte_valid && byte_ready.
- imem_we  out  1  instruction-memory write enable, one cycle per word.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  word to write.
- core_rst  out  1  active-high reset to the core; 1 holds the core.
- busy  out  1  load in progress.
- done  out  1  image loaded and core released.
- error  out  1  load failed (oversize length or timeout).

Behaviour:
- Reset values: core_rst=1, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0. State=IDLE, counters=0.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, RUN, ERROR.
- IDLE: core_rst=1. On start go to LEN_LO and clear word count, byte index, address and timeout.
- Stream format: 16-bit word count N, little-endian (LEN_LO then LEN_HI), then 4*N data bytes. Each group of four bytes forms one word, little-endian (first byte = bits 7:0).
- byte_ready=1 only in LEN_LO, LEN_HI and DATA; busy=1 in LEN_LO, LEN_HI, DATA and WRITE.
- LEN_HI, on handshake:
  - N==0 → RUN.
  - N>DEPTH → ERROR.
  - Otherwise → DATA.
- DATA: each handshake shifts the byte into the word assembly register and increments the byte index (0..3). On the 4th byte go to WRITE.
- WRITE (exactly 1 cycle):
  - imem_we=1, imem_addr=current address, imem_wdata=assembled word.
  - Next cycle: address+1 and words_written+1.
  - If words_written+1==N → RUN; else → DATA.
- Latency: imem_we asserts the cycle after the 4th byte's handshake edge. byte_ready=0 during WRITE, so at most one word is in flight.
- RUN: core_rst=0, done=1, imem_we=0. start → LEN_LO with core_rst=1 and done=0 from the next cycle.
- ERROR: core_rst=1, error=1. Partially written memory is left as-is. start → LEN_LO and clears error.
- Timeout:
  - Counter runs in LEN_LO, LEN_HI and DATA; cleared on every handshake and on state entry.
  - Reaching TIMEOUT_CYCLES → ERROR.
  - A handshake in the same cycle as the terminal count wins (byte accepted, no error).
- start while busy is ignored. byte_valid outside accepting states is ignored (no transfer).
- imem_addr wraps modulo 2**ADDR_WIDTH. N≤DEPTH guarantees no overwrite.
- Asynchronous reset mid-load returns to IDLE with reset values immediately. core_rst is forced to 1 asynchronously.

Test Plan:
- Reset asserted then deasserted, no start → core_rst=1, byte_ready=0, done=0, error=0; state remains IDLE for 50 cycles.
- start; stream 02 00 13 05 A0 00 93 05 50 00 → imem writes addr0=0x00A00513, addr1=0x00500593, one imem_we cycle each; then core_rst=0, done=1.
- start; stream 00 00 → no imem_we; RUN entered the cycle after LEN_HI handshake; done=1.
- start; stream 01 01 (N=257 > DEPTH 256) → error=1, core_rst=1, no imem_we. Then start plus a valid 1-word image → error clears, done=1.
- start; stream 01 00 AA, then byte_valid low for TIMEOUT_CYCLES → error=1, no write. Repeat with a byte arriving at exactly the terminal-count cycle → byte accepted, no error.
- Mid-load (after 3 words of 5) assert reset → all outputs at reset values immediately. After release, a start plus a full reload completes with done=1. start pulse while busy → no restart, word count unaffected.
